// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: slew-limited duty sequencer that steps level toward a target only on PWM period boundaries
module pwm_ramp_ctrl #(
  parameter int C_CLK_FRQ      = 100000000,
  parameter int C_LEVEL_WIDTH  = 8,
  parameter int C_STEP_PERIODS = 1
) (
  input  logic                     clk,
  input  logic                     rstb,
  input  logic [C_LEVEL_WIDTH-1:0] tgt,
  input  logic                     tgt_valid,
  output logic                     tgt_ready,
  input  logic [C_LEVEL_WIDTH-1:0] step,
  output logic [C_LEVEL_WIDTH-1:0] level,
  output logic                     busy,
  output logic                     done,
  output logic                     period_tick
);
  localparam int W = C_LEVEL_WIDTH;
  localparam int SW = $clog2(C_STEP_PERIODS + 1);
  localparam logic [1:0] IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2;
  if (C_STEP_PERIODS < 1 || C_CLK_FRQ < 1 || C_LEVEL_WIDTH < 1) begin : g_bad
    $error("pwm_ramp_ctrl: illegal parameters");
  end
  logic [1:0] state;
  logic [W-1:0] pcnt, tgtq, stepq, nxt;
  logic [SW-1:0] scnt;
  logic [W:0] sum, diff;
  logic accept, advance;
  assign tgt_ready = state == IDLE && !rstb;
  assign busy = state != IDLE;
  assign accept = tgt_valid && tgt_ready;
  assign advance = period_tick && scnt == SW'(C_STEP_PERIODS - 1);
  // W+1-bit arithmetic so the clamp to the target sees overflow/borrow instead of a wrapped value
  assign sum = {1'b0, level} + {1'b0, stepq};
  assign diff = {1'b0, level} - {1'b0, stepq};
  assign nxt = state == UP ? (sum > {1'b0, tgtq} ? tgtq : sum[W-1:0])
                           : (diff[W] || diff[W-1:0] < tgtq ? tgtq : diff[W-1:0]);
  always_ff @(posedge clk) begin
    if (rstb) begin
      state <= IDLE;
      pcnt <= '0;
      scnt <= '0;
      tgtq <= '0;
      stepq <= '0;
      level <= '0;
      done <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      pcnt <= pcnt + 1'b1;
      period_tick <= pcnt == W'(2 ** W - 2);
      done <= 1'b0;
      if (accept) begin
        tgtq <= tgt;
        stepq <= step == '0 ? W'(1) : step;
        scnt <= '0;
        state <= tgt > level ? UP : tgt < level ? DOWN : IDLE;
        done <= tgt == level;
      end else begin
        if (period_tick) scnt <= advance ? '0 : scnt + 1'b1;
        if (advance && busy) begin
          level <= nxt;
          if (nxt == tgtq) begin
            state <= IDLE;
            done <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: scoreboard bench; stimulus pushes expected level sequences, a monitor pops on every level change/done
module tb_pwm_ramp_ctrl;
  logic clk = 1'b0, rstb = 1'b1, tgt_valid = 1'b0;
  logic tgt_ready, busy, done, period_tick;
  logic [7:0] tgt = '0, step = '0, level;
  int passCnt = 0, totalCnt = 0;
  int expLevels[$];
  int expDone[$];
  int modelLevel = 0;
  int mcnt = 0;
  logic started = 1'b0, prevRst = 1'b1, prevTick = 1'b0, prevBusy = 1'b0;
  logic [7:0] prevLevel = '0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl dut (
    .clk(clk), .rstb(rstb), .tgt(tgt), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready),
    .step(step), .level(level), .busy(busy), .done(done), .period_tick(period_tick)
  );

  task automatic chk(input string name, input int act, input int exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // period counter reference: cleared by reset, otherwise counts modulo 256
  initial forever begin
    @(posedge clk);
    mcnt = rstb ? 0 : (mcnt + 1) % 256;
  end

  initial forever begin
    @(negedge clk);
    if (prevRst) started = 1'b1;
    if (started) begin
      if (prevRst) begin
        chk("rst_level", level, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tick", period_tick, 0);
      end else begin
        if (period_tick || mcnt == 255) chk("period_tick", period_tick, int'(mcnt == 255));
        if (level != prevLevel) begin
          chk("step_on_boundary", prevTick, 1);
          chk("busy_before_step", prevBusy, 1);
          if (expLevels.size() == 0) chk("unexpected_level", level, prevLevel);
          else chk("level", level, expLevels.pop_front());
        end
        if (done) begin
          chk("busy_at_done", busy, 0);
          if (expDone.size() == 0) chk("spurious_done", done, 0);
          else chk("done_level", level, expDone.pop_front());
        end
      end
      chk("tgt_ready", tgt_ready, int'(!rstb && !busy));
    end
    prevRst = rstb;
    prevTick = period_tick;
    prevBusy = busy;
    prevLevel = level;
  end

  task automatic issue(input int t, input int s);
    int ss, l, n;
    ss = s == 0 ? 1 : s;
    l = modelLevel;
    while (l != t) begin
      l = t > l ? (l + ss > t ? t : l + ss) : (l - ss < t ? t : l - ss);
      expLevels.push_back(l);
    end
    expDone.push_back(t);
    modelLevel = t;
    tgt = 8'(t);
    step = 8'(s);
    tgt_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tgt_ready && n < 3000);
    chk("accept", tgt_ready, 1);
    @(posedge clk);
    #1 tgt_valid = 1'b0;
  endtask

  task automatic waitIdle();
    int n = 0;
    while (expDone.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("completion", expDone.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int cycles);
    rstb = 1'b1;
    expLevels.delete();
    expDone.delete();
    modelLevel = 0;
    repeat (cycles) @(posedge clk);
    #1 rstb = 1'b0;
  endtask

  initial begin
    int t, s, n;
    repeat (5) @(posedge clk);
    #1 rstb = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", tgt_ready, 1);
    @(posedge clk);
    #1;
    issue(255, 64);
    waitIdle();
    issue(0, 100);
    waitIdle();
    issue(0, 7);
    @(negedge clk);
    chk("equal_busy", busy, 0);
    waitIdle();
    issue(3, 0);
    waitIdle();
    issue(200, 50);
    repeat (20) @(posedge clk);
    #1;
    issue(10, 95);
    waitIdle();
    doReset(2);
    issue(255, 64);
    n = 0;
    while (level != 8'd128 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("reach_128", level, 128);
    @(posedge clk);
    #1 doReset(1);
    repeat (300) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        s = 0;
        t = modelLevel + int'($urandom_range(0, 6)) - 3;
        t = t < 0 ? 0 : t > 255 ? 255 : t;
      end else begin
        s = $urandom_range(60, 255);
        t = $urandom_range(0, 255);
      end
      issue(t, s);
      waitIdle();
    end
    chk("levels_drained", expLevels.size(), 0);
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end
endmodule

// File: doc/pwm_ramp_ctrl.md
Name: pwm_ramp_ctrl

Overview:
- Slew-limited level sequencer that drives the `level` input of the `pwm` block.
- Accepts a target duty level through a valid/ready handshake.
- Steps its `level` output toward the target by a programmable increment, and only on PWM period boundaries. This keeps every PWM period at a single duty value and prevents abrupt duty jumps.
- Sits between the stimulus/control source (bench sequencer or a higher-level controller) and the `pwm` instance. `level` connects directly to `pwm.level`.

Parameters:
- C_CLK_FRQ, 100000000, main clock frequency [Hz]; informational, matches `pwm`.
- C_LEVEL_WIDTH, 8, level width W; PWM period = 2^W clocks; must match `pwm`.
- C_STEP_PERIODS, 1, number of PWM periods between ramp steps; legal range >= 1.

Ports:
- clk  in  1  main clock; all logic on rising edge.
- rstb  in  1  reset; one clock, reset is synchronous and active-high.
- tgt  in  W  requested target level.
- tgt_valid  in  1  target request valid.
- tgt_ready  out  1  controller can accept a target.
- step  in  W  ramp increment per step event; sampled with the target.
- level  out  W  current duty level, to `pwm.level`.
- busy  out  1  ramp in progress.
- done  out  1  one-cycle pulse when `level` reaches the accepted target.
- period_tick  out  1  one-cycle pulse on the last clock of each PWM period.

Behaviour:
- Reset (rstb=1 at an edge) forces:
  - level=0, busy=0, done=0, period_tick=0, tgt_ready=0;
  - period counter pcnt=0, step counter scnt=0;
  - state IDLE and the latched target/step registers cleared.
- Reset overrides everything, including mid-ramp; after release, state is IDLE with level=0.
- pcnt: W-bit free-running counter, increments every clock after reset, wraps 2^W-1 -> 0.
- period_tick: registered; equals 1 in the cycle where pcnt==2^W-1, so one pulse every 2^W clocks.
- Step event: period_tick=1 and scnt==C_STEP_PERIODS-1.
  - scnt increments on each period_tick and wraps to 0 at the step event.
  - scnt is cleared to 0 when a target is accepted.
- tgt_ready: equals 1 iff state==IDLE and rstb==0. It is combinational from state and rstb, so 0 in any cycle with rstb=1.
- Handshake: a target is accepted on an edge with tgt_valid=1 and tgt_ready=1.
  - tgt and step are latched as T and S.
  - A latched step of 0 is replaced by 1.
  - tgt_valid while busy is ignored; the requester holds it until tgt_ready.
- States:
  - IDLE: busy=0.
    - Accept with T==level: done=1 on the next cycle, remain IDLE, level unchanged.
    - Accept with T>level: go to UP, busy=1 from the next cycle.
    - Accept with T<level: go to DOWN, busy=1 from the next cycle.
  - UP: on each step event, level <= min(level+S, T).
    - The sum is computed in W+1 bits, so there is no wrap-around.
    - If the new level==T: state <= IDLE, done=1 in the following cycle, busy=0 in the same cycle as done.
  - DOWN: on each step event, level <= max(level-S, T).
    - The difference is computed in W+1 bits, so there is no underflow.
    - Completion follows the same rules as UP.
- level changes only on a step event edge, i.e. at a PWM period boundary. This holds in UP and DOWN only.
- Latency:
  - the first step is applied at the first step event after acceptance;
  - minimum latency from acceptance to the first level change is 1 clock (acceptance in the tick cycle does not step in that same cycle);
  - maximum latency is C_STEP_PERIODS*2^W clocks.
- Simultaneous events: acceptance and step event on the same edge → acceptance only; stepping starts at the next step event.
- Back-to-back requests: a new target can be accepted in the cycle after done (IDLE).
- Edge values: level never exceeds 2^W-1 and never goes below 0. T=2^W-1 with S=2^W-1 from 0 completes in a single step.

Test Plan (W=8, C_STEP_PERIODS=1, 10 ns clock, period 256 clocks):
- Reset: hold rstb=1 for 5 cycles, then 0 → during reset level=0, busy=0, done=0, tgt_ready=0; tgt_ready=1 the cycle after release; period_tick pulses every 256 clocks.
- Ramp up: from 0, tgt=255, step=64 → level 64, 128, 192, 255 on 4 consecutive period boundaries; done pulse exactly once after 255; busy low afterwards.
- Ramp down with clamp: from 255, tgt=0, step=100 → level 155, 55, 0; done once; level never wraps.
- Degenerate requests:
  - tgt equal to current level (e.g. 0) → done pulse next cycle, busy stays 0, level unchanged;
  - step=0 with tgt=3 from 0 → level 1, 2, 3.
- Ignored request: assert tgt_valid with tgt=10 while ramping 0→200 with step=50 → the ramp completes at 200 unaffected; tgt=10 is accepted only once tgt_ready=1.
- Reset mid-ramp: assert rstb after level reaches 128 (0→255, step=64) → next edge level=0, busy=0, state IDLE; no done pulse.
